// File: rtl/mine_place_ctrl_pkg.sv
// minesweeper_pkg: shared constants and the sequencer state type for the
// mine placement logic. No ports.
package minesweeper_pkg;

  localparam int CELLS     = 25;   // 5x5 board
  localparam int IDX_W     = 5;    // cell index / mine count width
  localparam int DATA_W    = 8;    // LCG state and parameter width
  localparam int TRY_W     = 8;    // attempt counter width
  localparam int MAX_TRIES = 255;  // attempts per run before giving up

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/mine_place_ctrl_if.sv
// mine_place_ctrl_if: request/parameter and result bundle between the
// game-control FSM (master) and the mine placement sequencer (slave).
//   in_start, in_seed, in_mult, in_increment, in_modulus, in_mine_num : request
//   in_safe_cell : excluded cell (only when MINE_SAFE_CELL_EN is defined)
//   out_mines, out_busy, out_done, out_error : result / status
interface mine_place_ctrl_if import minesweeper_pkg::*; ();

  logic              in_start;
  logic [DATA_W-1:0] in_seed;
  logic [DATA_W-1:0] in_mult;
  logic [DATA_W-1:0] in_increment;
  logic [DATA_W-1:0] in_modulus;
  logic [IDX_W-1:0]  in_mine_num;
`ifdef MINE_SAFE_CELL_EN
  logic [IDX_W-1:0]  in_safe_cell;
`endif
  logic [CELLS-1:0]  out_mines;
  logic              out_busy;
  logic              out_done;
  logic              out_error;

  modport master (
    output in_start, in_seed, in_mult, in_increment, in_modulus, in_mine_num,
`ifdef MINE_SAFE_CELL_EN
    output in_safe_cell,
`endif
    input  out_mines, out_busy, out_done, out_error
  );

  modport slave (
    input  in_start, in_seed, in_mult, in_increment, in_modulus, in_mine_num,
`ifdef MINE_SAFE_CELL_EN
    input  in_safe_cell,
`endif
    output out_mines, out_busy, out_done, out_error
  );

endinterface

// File: rtl/mine_place_ctrl_lcg_step.sv
// lcg_step: one combinational LCG step, xn = (a*x + c) mod m, plus the board
// cell it maps to, idx = xn mod CELLS.
//   x, a, c, m : current state and parameters (DATA_W each)
//   xn         : next state (DATA_W)
//   idx        : cell index, always < CELLS (IDX_W)
module lcg_step import minesweeper_pkg::*; (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] xn,
  output logic [IDX_W-1:0]  idx
);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W:0]   sum;
  logic [2*DATA_W:0]   divisor;

  always_comb begin
    prod    = (2*DATA_W)'(x) * (2*DATA_W)'(a);
    sum     = (2*DATA_W+1)'(prod) + (2*DATA_W+1)'(c);
    // m == 0 never reaches RUN; substitute 1 so the divider is always defined.
    divisor = (m == '0) ? (2*DATA_W+1)'(1) : (2*DATA_W+1)'(m);
    xn      = DATA_W'(sum % divisor);
    idx     = IDX_W'(xn % DATA_W'(CELLS));
  end

endmodule

// File: rtl/mine_place_ctrl.sv
// mine_place_ctrl: places in_mine_num distinct mines on the board using an
// LCG, one attempt per clock, and reports the bitmap on out_mines.
//   in_clka  : clock
//   in_reset : asynchronous active-high reset
//   bus      : mine_place_ctrl_if.slave (request parameters in, result out)
// Optional build macro MINE_SAFE_CELL_EN adds in_safe_cell, a cell that is
// never mined.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | one LCG attempt per clock
// DONE  | requested mines placed, bitmap held
// ERR   | bad parameters or attempt budget exhausted, bitmap cleared
module mine_place_ctrl import minesweeper_pkg::*; (
  input logic              in_clka,
  input logic              in_reset,
  mine_place_ctrl_if.slave bus
);

  state_t            state, state_n;
  logic [DATA_W-1:0] x, x_n, a, a_n, c, c_n, m, m_n;
  logic [IDX_W-1:0]  num, num_n, count, count_n;
  logic [TRY_W-1:0]  tries, tries_n;
  logic [CELLS-1:0]  mines, mines_n;
  logic [DATA_W-1:0] xn;
  logic [IDX_W-1:0]  idx;
  logic              param_err;
  logic              eligible;

`ifdef MINE_SAFE_CELL_EN
  logic [IDX_W-1:0]  safe, safe_n;
  assign param_err = (bus.in_modulus == '0) ||
                     (bus.in_mine_num > IDX_W'(CELLS - 1)) ||
                     (bus.in_safe_cell >= IDX_W'(CELLS));
  assign eligible  = (idx != safe);
`else
  assign param_err = (bus.in_modulus == '0) || (bus.in_mine_num > IDX_W'(CELLS));
  assign eligible  = 1'b1;
`endif

  lcg_step u_lcg (.x(x), .a(a), .c(c), .m(m), .xn(xn), .idx(idx));

  always_ff @(posedge in_clka or posedge in_reset) begin
    if (in_reset) begin
      state <= IDLE;
      x     <= '0;
      a     <= '0;
      c     <= '0;
      m     <= '0;
      num   <= '0;
      count <= '0;
      tries <= '0;
      mines <= '0;
`ifdef MINE_SAFE_CELL_EN
      safe  <= '0;
`endif
    end else begin
      state <= state_n;
      x     <= x_n;
      a     <= a_n;
      c     <= c_n;
      m     <= m_n;
      num   <= num_n;
      count <= count_n;
      tries <= tries_n;
      mines <= mines_n;
`ifdef MINE_SAFE_CELL_EN
      safe  <= safe_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    a_n     = a;
    c_n     = c;
    m_n     = m;
    num_n   = num;
    count_n = count;
    tries_n = tries;
    mines_n = mines;
`ifdef MINE_SAFE_CELL_EN
    safe_n  = safe;
`endif
    case (state)
      RUN: begin
        x_n     = xn;
        tries_n = tries + TRY_W'(1);
        if (!mines[idx] && eligible) begin
          mines_n[idx] = 1'b1;
          count_n      = count + IDX_W'(1);
        end
        // Reaching the target on the last allowed try still counts as success.
        if (count_n == num) begin
          state_n = DONE;
        end else if (tries_n == TRY_W'(MAX_TRIES)) begin
          state_n = ERR;
          mines_n = '0;
        end
      end
      default: begin
        if (bus.in_start) begin
          x_n     = bus.in_seed;
          a_n     = bus.in_mult;
          c_n     = bus.in_increment;
          m_n     = bus.in_modulus;
          num_n   = bus.in_mine_num;
`ifdef MINE_SAFE_CELL_EN
          safe_n  = bus.in_safe_cell;
`endif
          mines_n = '0;
          count_n = '0;
          tries_n = '0;
          if (param_err)                state_n = ERR;
          else if (bus.in_mine_num == '0) state_n = DONE;
          else                          state_n = RUN;
        end
      end
    endcase
  end

  assign bus.out_mines = mines;
  assign bus.out_busy  = (state == RUN);
  assign bus.out_done  = (state == DONE);
  assign bus.out_error = (state == ERR);

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Self-checking bench for mine_place_ctrl: directed cases plus randomized runs
// compared against a plain-arithmetic reference of the placement rules.
module tb_mine_place_ctrl;
  import minesweeper_pkg::*;

`ifdef MINE_SAFE_CELL_EN
  localparam bit SAFE_EN = 1'b1;
`else
  localparam bit SAFE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mine_place_ctrl_if bus();
  mine_place_ctrl dut (.in_clka(clk), .in_reset(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: safe < 0 means no excluded cell.
  task automatic model(input int seed, input int a, input int c, input int m,
                       input int num, input int safe,
                       output int t, output logic [31:0] mines, output bit err);
    bit used [CELLS];
    int x, idx, placed;
    bit perr;
    for (int i = 0; i < CELLS; i++) used[i] = 1'b0;
    t = 0; mines = 0; err = 1'b0; placed = 0; x = seed;
    if (safe >= 0) perr = (m == 0) || (num > CELLS - 1) || (safe >= CELLS);
    else           perr = (m == 0) || (num > CELLS);
    if (perr) begin
      err = 1'b1;
    end else if (num != 0) begin
      forever begin
        x = (a * x + c) % m;
        idx = x % CELLS;
        t++;
        if (idx != safe && !used[idx]) begin
          used[idx] = 1'b1;
          placed++;
          mines = mines | (32'd1 << idx);
        end
        if (placed == num) break;
        if (t == MAX_TRIES) begin
          err = 1'b1;
          mines = 0;
          break;
        end
      end
    end
  endtask

  task automatic set_params(input int seed, input int a, input int c, input int m,
                            input int num, input int safe);
    bus.in_seed      = 8'(seed);
    bus.in_mult      = 8'(a);
    bus.in_increment = 8'(c);
    bus.in_modulus   = 8'(m);
    bus.in_mine_num  = 5'(num);
`ifdef MINE_SAFE_CELL_EN
    bus.in_safe_cell = 5'(safe);
`endif
  endtask

  function automatic int sv(input int v);
    return SAFE_EN ? v : -1;
  endfunction

  task automatic run_case(input string tag, input int seed, input int a, input int c,
                          input int m, input int num, input int safe, input bit poke);
    int t;
    logic [31:0] exp_mines;
    bit exp_err;
    model(seed, a, c, m, num, safe, t, exp_mines, exp_err);
    @(negedge clk);
    set_params(seed, a, c, m, num, safe);
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    for (int k = 0; k < t; k++) begin
      check({tag, "_busy"}, bus.out_busy, 32'd1);
      set_params($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      bus.in_start = (poke && k == 1 && t > 2);
      @(negedge clk);
    end
    bus.in_start = 1'b0;
    check({tag, "_done"},  bus.out_done,  {31'd0, ~exp_err});
    check({tag, "_error"}, bus.out_error, {31'd0, exp_err});
    check({tag, "_idle"},  bus.out_busy,  32'd0);
    check({tag, "_mines"}, bus.out_mines, exp_mines);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_start = 1'b0;
    set_params(0, 0, 0, 0, 0, 0);
    #12;
    check("reset_mines", bus.out_mines, 32'd0);
    check("reset_busy",  bus.out_busy,  32'd0);
    check("reset_done",  bus.out_done,  32'd0);
    check("reset_error", bus.out_error, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("basic", 0, 1, 1, 25, 3, sv(2), 1'b1);
    check("basic_const", bus.out_mines, SAFE_EN ? 32'h1A : 32'hE);
    run_case("dup", 7, 1, 0, 25, 2, sv(24), 1'b0);
    run_case("m_zero", 3, 5, 1, 0, 4, sv(24), 1'b0);
    run_case("num_26", 0, 1, 1, 25, 26, sv(24), 1'b0);
    run_case("num_0", 0, 1, 1, 25, 0, sv(24), 1'b0);
    run_case("full", 0, 1, 1, 25, 25, sv(24), 1'b0);
    run_case("restart", 0, 1, 1, 25, 3, sv(2), 1'b0);

    // Reset mid-run: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    set_params(0, 1, 1, 25, 3, sv(2));
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mines", bus.out_mines, 32'd0);
    check("async_rst_busy",  bus.out_busy,  32'd0);
    check("async_rst_done",  bus.out_done,  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", bus.out_busy, 32'd0);
    run_case("after_rst", 0, 1, 1, 25, 3, sv(2), 1'b0);

    for (int i = 0; i < 25; i++) begin
      int m, num, safe;
      m    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      num  = $urandom_range(0, 26);
      safe = sv($urandom_range(0, 26));
      run_case($sformatf("rand%0d", i), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255), m, num, safe, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mine_place_ctrl.md
# mine_place_ctrl

Sequencer that builds the minesweeper mine bitmap from a linear congruential generator, X[n+1] = (a*X[n] + c) mod m. It runs one LCG step per clock, maps each value to a board cell, rejects duplicates, and stops once the requested number of distinct mines is placed. It sits between the game-control FSM, which issues start and the LCG parameters, and the board/display logic, which consumes `out_mines`.

## Interface
- `CELLS`, 25: number of board cells (5x5); width of `out_mines`.
- `DATA_W`, 8: width of LCG state and parameters.
- `MAX_TRIES`, 255: attempt budget per run before error.
- `in_clka` in 1: clock; all state changes on rising edge.
- `in_reset` in 1: one clock; reset is asynchronous and active-high. All state clears immediately.
- `in_start` in 1: run request, sampled in IDLE/DONE/ERR; ignored while busy.
- `in_seed` in DATA_W: X[0].
- `in_mult` in DATA_W: multiplier a.
- `in_increment` in DATA_W: increment c.
- `in_modulus` in DATA_W: modulus m; 0 is illegal.
- `in_mine_num` in 5: mines to place, 0..CELLS.
- `out_mines` out CELLS: bit i = 1 means cell i holds a mine.
- `out_busy` out 1: high in RUN.
- `out_done` out 1: level, high in DONE.
- `out_error` out 1: level, high in ERR.

## Operation
- States: IDLE, RUN, DONE, ERR. Reset → IDLE, with all outputs 0, X=0, count=0, tries=0.
- On start in IDLE/DONE/ERR:
  - Parameters are captured into registers.
  - X←seed, mines←0, count←0, tries←0.
  - If m==0 or mine_num>CELLS, go to ERR.
  - Else if mine_num==0, go to DONE.
  - Else go to RUN.
- RUN, one attempt per edge:
  - Xn = (a*X + c) mod m.
  - X←Xn; idx = Xn mod CELLS; tries←tries+1.
  - If mines[idx]==0: set the bit and count←count+1.
- Exit from RUN:
  - If the new count==mine_num, go to DONE. This takes priority over the timeout.
  - Else if the new tries==MAX_TRIES, go to ERR with out_mines cleared to 0.
- DONE/ERR hold their outputs until the next start or reset.
- Arithmetic:
  - a*X is 2*DATA_W bits; +c is 2*DATA_W+1 bits; there is no truncation before the mod.
  - Xn is DATA_W bits.
  - idx is 5 bits, always <CELLS.
- Parameter inputs may change during RUN without effect, because only the captured copies are used.

## Timing
- Start sampled at edge 0 leaves IDLE after edge 0.
- Attempt k occurs at edge k.
- out_done rises after edge T, where T is the number of attempts.
  - Minimum latency with all attempts fresh: mine_num edges.
  - Maximum: MAX_TRIES edges, then ERR.
- mine_num==0 or a parameter error: out_done/out_error is high after edge 0.
- out_mines updates combinationally from the register; bits appear one edge after their attempt.
- Reset asserted mid-RUN: immediate IDLE, all outputs 0, no partial result retained.

## Configuration
- `MINE_SAFE_CELL_EN`: adds input `in_safe_cell` (5 bits), captured at start.
  - A candidate idx equal to the safe cell is rejected and still consumes a try.
  - mine_num>CELLS-1 or safe_cell≥CELLS is a parameter error (ERR after edge 0).
- Without the macro: no port and no exclusion; every cell is eligible.

## Structure
- Package `minesweeper_pkg`:
  - CELLS, IDX_W=5, DATA_W, MAX_TRIES.
  - State enum for {IDLE, RUN, DONE, ERR}.
- Sub-module `lcg_step`: combinational; takes X, a, c, m and outputs Xn and idx. It is reusable by later board-shuffle logic.
- The controller holds the FSM, the count/tries counters and the mines register.

## Test plan
- Basic run: seed=0, a=1, c=1, m=25, mine_num=3, start at edge 0 → out_mines=25'h000000E, out_done high after edge 3, out_busy high after edges 0–2.
- Duplicates: seed=7, a=1, c=0, m=25, mine_num=2 → bit 7 set at edge 1, then repeats. ERR after edge 255 with out_mines=0.
- Illegal parameters: m=0 → out_error after edge 0. mine_num=26 → out_error after edge 0. mine_num=0 → out_done after edge 0 with out_mines=0.
- Reset and restart:
  - Assert in_reset at edge 2 of the basic run → outputs 0 asynchronously, state IDLE.
  - Start pulsed during RUN is ignored.
  - Start in DONE restarts and clears mines.
- Full board: a=1, c=1, m=25, seed=0, mine_num=25 → out_mines=25'h1FFFFFF after edge 25.
- With MINE_SAFE_CELL_EN: safe_cell=2 on the basic run → idx 2 is rejected, out_mines=25'h000001A, out_done after edge 4.
